uart_rx_fsm: RTL

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/rx_edge_bit_counter.sv | 38 +++
 rtl/uart_rx_fsm.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Unsupported oversampling ratios fall back to x8 so the bit timing never
  // degenerates (e.g. a ratio of 0 would never reach its terminal count).
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) begin
      return p;
    end
    return PRESCALE_8;
  endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// The edge count wraps at prescale-1 and advances the bit count.
module rx_edge_bit_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_cnt_en,
  input  logic       i_clear,
  input  logic [5:0] i_prescale,
  output logic [5:0] o_edge_cnt,
  output logic [3:0] o_bit_cnt,
  output logic       o_bit_end
);

  logic [5:0] r_edge_cnt;
  logic [3:0] r_bit_cnt;

  assign o_bit_end  = (r_edge_cnt == (i_prescale - 6'd1));
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

  // Count oversample edges; both counters sit at 0 whenever disabled or when
  // the frame is finishing, so IDLE/DONE always present zero counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= 4'd0;
    end else if (!i_cnt_en || i_clear) begin
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= 4'd0;
    end else if (o_bit_end) begin
      r_edge_cnt <= 6'd0;
      r_bit_cnt  <= r_bit_cnt + 4'd1;
    end else begin
      r_edge_cnt <= r_edge_cnt + 6'd1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencing FSM: walks start/data/parity/stop bits and
// strobes the external start, data, parity and stop checkers at mid-bit.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low level
//   START  | start bit, glitch check at mid-bit
//   DATA   | data bits 1..DATA_WIDTH, shifted into the deserializer
//   PARITY | optional parity bit
//   STOP   | stop bit
//   DONE   | one-cycle frame end, data_valid when no error captured
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       EN,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       start_glitch,
  input  logic       par_err,
  input  logic       stop_err,
  output logic       sample_en,
  output logic       start_check_en,
  output logic       par_check_en,
  output logic       stop_check_en,
  output logic       deser_en,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       data_valid
);

  localparam logic [3:0] LP_LAST_BIT = 4'(DATA_WIDTH);

  rx_state_t  r_state;
  logic [5:0] r_prescale;
  logic       r_par_en;
  logic       r_par_flag;
  logic       r_stop_flag;

  logic       w_idle_like;
  logic       w_cnt_en;
  logic       w_bit_end;
  logic       w_frame_end;
  logic [5:0] w_mid;
  logic       w_at_mid;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_cnt_en    = EN && (!w_idle_like || !RX_IN);
  assign w_frame_end = w_bit_end &&
                       (((r_state == ST_START) && start_glitch) || (r_state == ST_STOP));
  assign w_mid       = (r_prescale >> 1) + 6'd2;
  assign w_at_mid    = (edge_cnt == w_mid);

  rx_edge_bit_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cnt_en   (w_cnt_en),
    .i_clear    (w_frame_end),
    .i_prescale (r_prescale),
    .o_edge_cnt (edge_cnt),
    .o_bit_cnt  (bit_cnt),
    .o_bit_end  (w_bit_end)
  );

  // Frame sequencing, config capture between frames and error flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prescale  <= PRESCALE_8;
      r_par_en    <= 1'b0;
      r_par_flag  <= 1'b0;
      r_stop_flag <= 1'b0;
    end else if (!EN) begin
      r_state     <= ST_IDLE;
      r_par_flag  <= 1'b0;
      r_stop_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_prescale <= legal_prescale(Prescale);
          r_par_en   <= PAR_EN;
          if (!RX_IN) begin
            r_state     <= ST_START;
            r_par_flag  <= 1'b0;
            r_stop_flag <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_START: begin
          if (w_bit_end) r_state <= start_glitch ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (w_bit_end && (bit_cnt == LP_LAST_BIT)) begin
            r_state <= r_par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_par_flag <= par_err;
            r_state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_stop_flag <= stop_err;
            r_state     <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output decode purely from registered state, counters and flags.
  always_comb begin
    sample_en      = (r_state == ST_START) || (r_state == ST_DATA) ||
                     (r_state == ST_PARITY) || (r_state == ST_STOP);
    start_check_en = (r_state == ST_START)  && w_at_mid;
    deser_en       = (r_state == ST_DATA)   && w_at_mid;
    par_check_en   = (r_state == ST_PARITY) && w_at_mid;
    stop_check_en  = (r_state == ST_STOP)   && w_at_mid;
    data_valid     = (r_state == ST_DONE) && !r_par_flag && !r_stop_flag;
  end

endmodule
